// File: rtl/mem_access_unit_if.sv
// Data-side SRAM-like bus between the memory-stage load/store unit and data memory.
// Two-phase handshake: addr_ok accepts the request, data_ok completes it.
interface mem_access_unit_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          data_req;
    logic          data_wr;
    logic [1:0]    data_size;
    logic [AW-1:0] data_addr;
    logic [3:0]    data_wstrb;
    logic [DW-1:0] data_wdata;
    logic          data_addr_ok;
    logic          data_data_ok;
    logic [DW-1:0] data_rdata;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: issues one bus access per M-stage memory op,
// stalls the pipeline until it completes and returns the extended load data.
module mem_access_unit #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_en,
    input  logic [2:0]        mem_op,
    input  logic [AW-1:0]     addr_i,
    input  logic [DW-1:0]     wdata_i,
    input  logic              flush_i,
    input  logic              pipe_adv,
    output logic              stall_o,
    output logic [DW-1:0]     rdata_o,
    output logic              adel_o,
    output logic              ades_o,
    mem_access_unit_if.master bus
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, DRAIN} state_e;

    localparam logic [2:0] OP_LB  = 3'b000;
    localparam logic [2:0] OP_LBU = 3'b001;
    localparam logic [2:0] OP_LH  = 3'b010;
    localparam logic [2:0] OP_LHU = 3'b011;
    localparam logic [2:0] OP_LW  = 3'b100;
    localparam logic [2:0] OP_SB  = 3'b101;
    localparam logic [2:0] OP_SH  = 3'b110;
    localparam logic [2:0] OP_SW  = 3'b111;

    state_e        state_q, state_d;
    logic          cancel_q, cancel_d;
    logic [2:0]    op_q, op_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;

    logic          isHalf, isWord, isStore, mis, go;
    logic          qStore;
    logic [DW-1:0] byteSh, halfSh, loadExt;

    always_comb begin
        isHalf  = (mem_op == OP_LH) || (mem_op == OP_LHU) || (mem_op == OP_SH);
        isWord  = (mem_op == OP_LW) || (mem_op == OP_SW);
        isStore = (mem_op == OP_SB) || (mem_op == OP_SH) || (mem_op == OP_SW);
        mis     = (isHalf && addr_i[0]) || (isWord && (addr_i[1:0] != 2'b00));
        go      = mem_en && !mis && !flush_i;
        adel_o  = mem_en && mis && !isStore;
        ades_o  = mem_en && mis && isStore;
    end

    // Bus fields come only from the registered copies so they stay stable while req waits.
    always_comb begin
        qStore          = (op_q == OP_SB) || (op_q == OP_SH) || (op_q == OP_SW);
        bus.data_req    = (state_q == REQ);
        bus.data_wr     = qStore;
        bus.data_addr   = addr_q;
        bus.data_size   = 2'd2;
        bus.data_wstrb  = 4'b0000;
        bus.data_wdata  = wdata_q;
        case (op_q)
            OP_LB, OP_LBU: bus.data_size = 2'd0;
            OP_LH, OP_LHU: bus.data_size = 2'd1;
            OP_SB: begin
                bus.data_size  = 2'd0;
                bus.data_wstrb = 4'b0001 << addr_q[1:0];
                bus.data_wdata = {(DW/8){wdata_q[7:0]}};
            end
            OP_SH: begin
                bus.data_size  = 2'd1;
                bus.data_wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
                bus.data_wdata = {(DW/16){wdata_q[15:0]}};
            end
            OP_SW: bus.data_wstrb = 4'b1111;
            default: ;
        endcase
    end

    always_comb begin
        byteSh  = bus.data_rdata >> {addr_q[1:0], 3'b000};
        halfSh  = bus.data_rdata >> {addr_q[1], 4'b0000};
        loadExt = bus.data_rdata;
        case (op_q)
            OP_LB:   loadExt = {{(DW-8){byteSh[7]}}, byteSh[7:0]};
            OP_LBU:  loadExt = {{(DW-8){1'b0}}, byteSh[7:0]};
            OP_LH:   loadExt = {{(DW-16){halfSh[15]}}, halfSh[15:0]};
            OP_LHU:  loadExt = {{(DW-16){1'b0}}, halfSh[15:0]};
            default: ;
        endcase
    end

    // A flushed request cannot be withdrawn, so it is remembered in cancel_q and drained.
    always_comb begin
        state_d  = state_q;
        cancel_d = cancel_q;
        op_d     = op_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        stall_o  = 1'b0;
        case (state_q)
            IDLE: begin
                stall_o  = go;
                cancel_d = 1'b0;
                if (go) begin
                    op_d    = mem_op;
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                    state_d = REQ;
                end
            end
            REQ: begin
                stall_o = 1'b1;
                if (flush_i) cancel_d = 1'b1;
                if (bus.data_addr_ok) begin
                    state_d  = (cancel_q || flush_i) ? DRAIN : WAIT;
                    cancel_d = 1'b0;
                end
            end
            WAIT: begin
                stall_o = 1'b1;
                if (flush_i) begin
                    state_d = bus.data_data_ok ? IDLE : DRAIN;
                end else if (bus.data_data_ok) begin
                    if (!qStore) rdata_d = loadExt;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (flush_i || pipe_adv) state_d = IDLE;
            end
            DRAIN: begin
                stall_o = mem_en;
                if (bus.data_data_ok) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cancel_q <= 1'b0;
            op_q     <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cancel_q <= cancel_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads, stores, misalignment, bus wait states,
// flushes in REQ/WAIT and reset in the middle of a transaction.
module tb_mem_access_unit;
    localparam logic [2:0] LB = 3'b000, LBU = 3'b001, LH = 3'b010, LHU = 3'b011,
                           LW = 3'b100, SB = 3'b101, SH = 3'b110, SW = 3'b111;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_en;
    logic [2:0]  mem_op;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        flush_i;
    logic        pipe_adv;
    logic        stall_o;
    logic [31:0] rdata_o;
    logic        adel_o;
    logic        ades_o;

    int testsRun = 0;
    int testsFailed = 0;

    int          stallCnt;
    int          reqCnt;
    logic        addrStable;
    logic        timedOut;
    logic [31:0] obsAddr;
    logic [3:0]  obsWstrb;
    logic [31:0] obsWdata;
    logic [1:0]  obsSize;
    logic        obsWr;

    mem_access_unit_if #(.AW(32), .DW(32)) bus ();

    mem_access_unit #(.AW(32), .DW(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .mem_en   (mem_en),
        .mem_op   (mem_op),
        .addr_i   (addr_i),
        .wdata_i  (wdata_i),
        .flush_i  (flush_i),
        .pipe_adv (pipe_adv),
        .stall_o  (stall_o),
        .rdata_o  (rdata_o),
        .adel_o   (adel_o),
        .ades_o   (ades_o),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one access from IDLE until stall_o drops, acting as the memory.
    task automatic do_access(input logic [2:0] op, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] rdata,
                             input int aokDelay);
        logic pend;
        stallCnt   = 0;
        reqCnt     = 0;
        addrStable = 1'b1;
        timedOut   = 1'b1;
        pend       = 1'b0;
        mem_en  = 1'b1;
        mem_op  = op;
        addr_i  = addr;
        wdata_i = wdata;
        for (int c = 0; c < 40; c++) begin
            bus.data_data_ok = pend;
            bus.data_rdata   = pend ? rdata : 32'h0;
            pend             = 1'b0;
            bus.data_addr_ok = 1'b0;
            if (bus.data_req) begin
                if (reqCnt == 0) begin
                    obsAddr  = bus.data_addr;
                    obsWstrb = bus.data_wstrb;
                    obsWdata = bus.data_wdata;
                    obsSize  = bus.data_size;
                    obsWr    = bus.data_wr;
                end else if (bus.data_addr !== obsAddr) begin
                    addrStable = 1'b0;
                end
                if (reqCnt >= aokDelay) begin
                    bus.data_addr_ok = 1'b1;
                    pend = 1'b1;
                end
                reqCnt++;
            end
            #1;
            if (stall_o === 1'b0) begin
                timedOut = 1'b0;
                break;
            end
            stallCnt++;
            tick();
        end
        bus.data_addr_ok = 1'b0;
        bus.data_data_ok = 1'b0;
    endtask

    task automatic retire();
        pipe_adv = 1'b1;
        tick();
        pipe_adv = 1'b0;
        mem_en   = 1'b0;
        flush_i  = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        testsRun++;
        if (stall_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_stall: got %b expected 0", stall_o); end
        testsRun++;
        if (bus.data_req !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_req: got %b expected 0", bus.data_req); end
        testsRun++;
        if (rdata_o !== 32'h0) begin testsFailed++; $display("[TB] FAIL reset_rdata: got %h expected 00000000", rdata_o); end
        testsRun++;
        if ({bus.data_wr, bus.data_wstrb} !== 5'b0) begin testsFailed++; $display("[TB] FAIL reset_bus: got wr=%b wstrb=%b expected 0", bus.data_wr, bus.data_wstrb); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_load_extend();
        logic [2:0]  ops [5] = '{LB, LBU, LH, LHU, LW};
        logic [31:0] adr [5] = '{32'h1003, 32'h1003, 32'h1002, 32'h1000, 32'h1000};
        logic [31:0] exp [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00001234, 32'h80FF1234};
        for (int i = 0; i < 5; i++) begin
            do_access(ops[i], adr[i], 32'h0, 32'h80FF1234, 0);
            testsRun++;
            if (timedOut) begin testsFailed++; $display("[TB] FAIL load%0d_timeout: got no completion expected stall release", i); end
            testsRun++;
            if (stallCnt != 3) begin testsFailed++; $display("[TB] FAIL load%0d_stall: got %0d cycles expected 3", i, stallCnt); end
            testsRun++;
            if (rdata_o !== exp[i]) begin testsFailed++; $display("[TB] FAIL load%0d_rdata: got %h expected %h", i, rdata_o, exp[i]); end
            testsRun++;
            if ({obsWr, obsWstrb} !== 5'b0) begin testsFailed++; $display("[TB] FAIL load%0d_bus: got wr=%b wstrb=%b expected 0", i, obsWr, obsWstrb); end
            retire();
        end
    endtask

    task automatic test_store();
        logic [2:0]  ops [3] = '{SH, SB, SW};
        logic [31:0] adr [3] = '{32'h2002, 32'h3001, 32'h3004};
        logic [31:0] wd  [3] = '{32'h0000ABCD, 32'h0000005A, 32'hCAFEF00D};
        logic [31:0] ewd [3] = '{32'hABCDABCD, 32'h5A5A5A5A, 32'hCAFEF00D};
        logic [3:0]  est [3] = '{4'b1100, 4'b0010, 4'b1111};
        logic [1:0]  esz [3] = '{2'd1, 2'd0, 2'd2};
        logic [31:0] prev;
        for (int i = 0; i < 3; i++) begin
            prev = rdata_o;
            do_access(ops[i], adr[i], wd[i], 32'hFFFFFFFF, 0);
            testsRun++;
            if (timedOut || stallCnt != 3) begin testsFailed++; $display("[TB] FAIL store%0d_stall: got %0d cycles expected 3", i, stallCnt); end
            testsRun++;
            if (obsWstrb !== est[i]) begin testsFailed++; $display("[TB] FAIL store%0d_wstrb: got %b expected %b", i, obsWstrb, est[i]); end
            testsRun++;
            if (obsWdata !== ewd[i]) begin testsFailed++; $display("[TB] FAIL store%0d_wdata: got %h expected %h", i, obsWdata, ewd[i]); end
            testsRun++;
            if ({obsWr, obsSize} !== {1'b1, esz[i]}) begin testsFailed++; $display("[TB] FAIL store%0d_wr_size: got %b/%0d expected 1/%0d", i, obsWr, obsSize, esz[i]); end
            testsRun++;
            if (obsAddr !== adr[i]) begin testsFailed++; $display("[TB] FAIL store%0d_addr: got %h expected %h", i, obsAddr, adr[i]); end
            testsRun++;
            if (rdata_o !== prev) begin testsFailed++; $display("[TB] FAIL store%0d_rdata: got %h expected %h", i, rdata_o, prev); end
            retire();
        end
    endtask

    task automatic test_misaligned();
        logic [2:0]  ops [4] = '{LW, SH, LH, SW};
        logic [31:0] adr [4] = '{32'h1002, 32'h2001, 32'h1001, 32'h3003};
        logic        eL  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic        eS  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic        sawReq;
        for (int i = 0; i < 4; i++) begin
            mem_en = 1'b1;
            mem_op = ops[i];
            addr_i = adr[i];
            #1;
            testsRun++;
            if ({adel_o, ades_o} !== {eL[i], eS[i]}) begin testsFailed++; $display("[TB] FAIL mis%0d_flags: got adel=%b ades=%b expected %b %b", i, adel_o, ades_o, eL[i], eS[i]); end
            testsRun++;
            if (stall_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL mis%0d_stall: got %b expected 0", i, stall_o); end
            sawReq = 1'b0;
            for (int c = 0; c < 3; c++) begin
                tick();
                if (bus.data_req !== 1'b0 || stall_o !== 1'b0) sawReq = 1'b1;
            end
            testsRun++;
            if (sawReq) begin testsFailed++; $display("[TB] FAIL mis%0d_noreq: got req/stall activity expected none", i); end
        end
        mem_en = 1'b0;
        mem_op = LW;
        addr_i = 32'h1002;
        #1;
        testsRun++;
        if (adel_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL mis_disabled: got adel=%b expected 0", adel_o); end
        tick();
    endtask

    task automatic test_addr_wait();
        logic holdBad;
        do_access(LW, 32'h1000, 32'h0, 32'h12345678, 3);
        testsRun++;
        if (timedOut || stallCnt != 6) begin testsFailed++; $display("[TB] FAIL wait_stall: got %0d cycles expected 6", stallCnt); end
        testsRun++;
        if (reqCnt != 4) begin testsFailed++; $display("[TB] FAIL wait_req_cycles: got %0d expected 4", reqCnt); end
        testsRun++;
        if (!addrStable || obsAddr !== 32'h1000) begin testsFailed++; $display("[TB] FAIL wait_addr: got %h stable=%b expected 00001000 stable", obsAddr, addrStable); end
        testsRun++;
        if (rdata_o !== 32'h12345678) begin testsFailed++; $display("[TB] FAIL wait_rdata: got %h expected 12345678", rdata_o); end
        holdBad = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (stall_o !== 1'b0 || bus.data_req !== 1'b0 || rdata_o !== 32'h12345678) holdBad = 1'b1;
        end
        testsRun++;
        if (holdBad) begin testsFailed++; $display("[TB] FAIL done_hold: got activity in DONE expected idle hold with 12345678"); end
        retire();
    endtask

    task automatic test_flush_wait();
        logic [31:0] prev;
        prev = rdata_o;
        mem_en = 1'b1; mem_op = LW; addr_i = 32'h1004;
        tick();
        bus.data_addr_ok = 1'b1;
        tick();
        bus.data_addr_ok = 1'b0; flush_i = 1'b1; mem_en = 1'b0;
        tick();
        flush_i = 1'b0; mem_en = 1'b1; mem_op = SB; addr_i = 32'h3002; wdata_i = 32'h00000077;
        #1;
        testsRun++;
        if (stall_o !== 1'b1 || bus.data_req !== 1'b0) begin testsFailed++; $display("[TB] FAIL drain_stall: got stall=%b req=%b expected 1 0", stall_o, bus.data_req); end
        tick();
        bus.data_data_ok = 1'b1; bus.data_rdata = 32'hDEADBEEF;
        #1;
        testsRun++;
        if (stall_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL drain_stall2: got %b expected 1", stall_o); end
        tick();
        bus.data_data_ok = 1'b0; bus.data_rdata = 32'h0;
        #1;
        testsRun++;
        if (rdata_o !== prev) begin testsFailed++; $display("[TB] FAIL drain_rdata: got %h expected %h", rdata_o, prev); end
        testsRun++;
        if (stall_o !== 1'b1 || bus.data_req !== 1'b0) begin testsFailed++; $display("[TB] FAIL sb_launch: got stall=%b req=%b expected 1 0", stall_o, bus.data_req); end
        tick();
        testsRun++;
        if (bus.data_req !== 1'b1 || bus.data_wstrb !== 4'b0100 || bus.data_wdata !== 32'h77777777) begin
            testsFailed++; $display("[TB] FAIL sb_bus: got req=%b wstrb=%b wdata=%h expected 1 0100 77777777", bus.data_req, bus.data_wstrb, bus.data_wdata);
        end
        bus.data_addr_ok = 1'b1;
        tick();
        bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1; bus.data_rdata = 32'hFFFFFFFF;
        tick();
        bus.data_data_ok = 1'b0;
        #1;
        testsRun++;
        if (stall_o !== 1'b0 || rdata_o !== prev) begin testsFailed++; $display("[TB] FAIL sb_done: got stall=%b rdata=%h expected 0 %h", stall_o, rdata_o, prev); end
        retire();
    endtask

    task automatic test_flush_req();
        logic [31:0] prev;
        prev = rdata_o;
        mem_en = 1'b1; mem_op = LW; addr_i = 32'h1008;
        tick();
        flush_i = 1'b1; mem_en = 1'b0;
        tick();
        flush_i = 1'b0;
        #1;
        testsRun++;
        if (bus.data_req !== 1'b1 || bus.data_addr !== 32'h1008) begin testsFailed++; $display("[TB] FAIL cancel_req_held: got req=%b addr=%h expected 1 00001008", bus.data_req, bus.data_addr); end
        bus.data_addr_ok = 1'b1;
        tick();
        bus.data_addr_ok = 1'b0;
        #1;
        testsRun++;
        if (bus.data_req !== 1'b0 || stall_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL cancel_drain: got req=%b stall=%b expected 0 0", bus.data_req, stall_o); end
        bus.data_data_ok = 1'b1; bus.data_rdata = 32'h55555555;
        tick();
        bus.data_data_ok = 1'b0; bus.data_rdata = 32'h0;
        tick();
        testsRun++;
        if (rdata_o !== prev) begin testsFailed++; $display("[TB] FAIL cancel_rdata: got %h expected %h", rdata_o, prev); end
    endtask

    task automatic test_reset_mid();
        mem_en = 1'b1; mem_op = LHU; addr_i = 32'h1000;
        tick();
        bus.data_addr_ok = 1'b1;
        tick();
        bus.data_addr_ok = 1'b0;
        #1;
        testsRun++;
        if (stall_o !== 1'b1 || rdata_o === 32'h0) begin testsFailed++; $display("[TB] FAIL rstmid_pre: got stall=%b rdata=%h expected 1 nonzero", stall_o, rdata_o); end
        rst = 1'b1; mem_en = 1'b0;
        tick();
        testsRun++;
        if (bus.data_req !== 1'b0 || stall_o !== 1'b0 || rdata_o !== 32'h0) begin
            testsFailed++; $display("[TB] FAIL rstmid_state: got req=%b stall=%b rdata=%h expected 0 0 00000000", bus.data_req, stall_o, rdata_o);
        end
        rst = 1'b0;
        tick();
        do_access(LW, 32'h100C, 32'h0, 32'h0BADF00D, 0);
        testsRun++;
        if (timedOut || stallCnt != 3 || rdata_o !== 32'h0BADF00D) begin
            testsFailed++; $display("[TB] FAIL rstmid_after: got stall=%0d rdata=%h expected 3 0badf00d", stallCnt, rdata_o);
        end
        retire();
    endtask

    initial begin
        rst = 1'b0; mem_en = 1'b0; mem_op = 3'b000; addr_i = '0; wdata_i = '0;
        flush_i = 1'b0; pipe_adv = 1'b0;
        bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = '0;
        test_reset();
        test_load_extend();
        test_store();
        test_misaligned();
        test_addr_wait();
        test_flush_wait();
        test_flush_req();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage load/store unit. Sits directly downstream of the execute/memory pipeline register: it consumes the M-stage address, store data and access type, and drives a data-side SRAM-like bus (req/addr_ok/data_ok).
- Returns sign/zero-extended load data toward the M→W register.
- Produces the memory-stage stall, plus address-error flags for misaligned accesses.

Parameters:
- AW, 32, address width.
- DW, 32, data width; fixed byte lanes, DW/8 = 4.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset; one clock
- mem_en  in  1  M-stage instruction is a load/store
- mem_op  in  3  000 LB, 001 LBU, 010 LH, 011 LHU, 100 LW, 101 SB, 110 SH, 111 SW
- addr_i  in  AW  effective address (aluoutM)
- wdata_i  in  DW  store data (writedataM)
- flush_i  in  1  M-stage flush
- pipe_adv  in  1  M→W register loads this cycle
- stall_o  out  1  hold pipeline at M
- rdata_o  out  DW  extended load result
- adel_o  out  1  load address error
- ades_o  out  1  store address error
- data_req  out  1  bus request
- data_wr  out  1  1 = write
- data_size  out  2  0 byte, 1 half, 2 word
- data_addr  out  AW  bus address
- data_wstrb  out  4  byte enables
- data_wdata  out  DW  bus write data
- data_addr_ok  in  1  address phase accepted
- data_data_ok  in  1  data phase complete
- data_rdata  in  DW  bus read data

Behaviour:
- Reset values:
  - state = IDLE.
  - All outputs 0, including rdata_o, data_req, stall_o and cancel flag.
- Alignment (combinational on inputs):
  - mis = (half op & addr_i[0]) | (word op & addr_i[1:0] != 0).
  - adel_o = mem_en & mis & load.
  - ades_o = mem_en & mis & store.
  - On mis, no request is issued and stall_o = 0.
- Launch condition: go = mem_en & ~mis & ~flush_i.
- States:
  - IDLE:
    - stall_o = go.
    - On go: register op, addr_i, wdata_i; go to REQ.
  - REQ:
    - data_req = 1; bus fields driven from the registered copies and held stable until data_addr_ok.
    - On data_addr_ok go to WAIT (same cycle data_data_ok is not possible; the bus guarantees ≥1 cycle).
    - stall_o = 1.
  - WAIT:
    - data_req = 0; stall_o = 1.
    - On data_data_ok: capture the extended load into rdata_o (stores leave rdata_o unchanged); go to DONE.
  - DONE:
    - stall_o = 0; rdata_o stable.
    - On pipe_adv go to IDLE; else stay in DONE (another stage is stalling).
  - DRAIN:
    - Waits for data_data_ok, discards the data, then goes to IDLE.
    - stall_o = mem_en, so a new access waits.
- Flush handling:
  - flush_i in REQ: set cancel; req stays asserted until addr_ok (no withdrawal); then go to DRAIN.
  - flush_i in WAIT: go to DRAIN.
  - flush_i in DONE: go to IDLE.
  - Cancelled accesses never update rdata_o.
- Bus encoding:
  - data_size: 0 byte, 1 half, 2 word.
  - data_addr = full registered address.
  - SB: byte replicated to all 4 lanes; wstrb = 1 << a[1:0].
  - SH: half replicated to both halves; wstrb = a[1] ? 1100 : 0011.
  - SW: wstrb = 1111.
  - Loads: wstrb = 0000, data_wr = 0.
- Load extraction: select by registered a[1:0] (byte lane a*8, half lane a[1]*16). LB/LH sign-extend; LBU/LHU zero-extend.
- Latency: minimum 4 cycles from launch to stall_o low (IDLE, REQ, WAIT, DONE) with addr_ok in the first REQ cycle and data_ok one cycle later.
- Reset mid-transaction: returns to IDLE immediately. The bus is reset in the same domain, so no drain is needed.

Test Plan:
- LB at 0x1003, bus returns 0x80FF1234 → rdata_o = 0xFFFFFF80. LBU at the same address → 0x00000080. stall_o high for exactly 3 cycles with zero-wait bus.
- SH at 0x2002, wdata_i = 0x0000ABCD → data_wstrb = 1100, data_wdata = 0xABCDABCD, data_size = 1, data_wr = 1.
- LW at 0x1002 → adel_o = 1, data_req never asserted, stall_o = 0. SH at 0x2001 → ades_o = 1.
- LW with data_addr_ok delayed 3 cycles → data_req held 4 cycles with data_addr constant. Data 0x12345678 → rdata_o = 0x12345678; DONE held while pipe_adv = 0.
- LW flushed in WAIT → DRAIN. data_data_ok with 0xDEADBEEF leaves rdata_o at its prior value. A following SB waits (stall_o = 1) until the drain completes.
- rst asserted during WAIT → next edge: state IDLE, data_req = 0, stall_o = 0, rdata_o = 0.
